// File: rtl/uart_rx_dma_pkg.sv
// Shared definitions for the UART receive DMA block.
// Contents: arbiter state encoding, default receive-window limits and the
// write-pointer advance helper.
package uart_rx_dma_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_CPU  = 2'd1,
      ARB_DMA  = 2'd2
   } arb_state_e;

   localparam logic [31:0] DEF_ADR_LL = 32'h00C0_0000;
   localparam logic [31:0] DEF_ADR_UL = 32'h00C1_0000;

   // Next word address inside [ll, ul); wraps back to ll at the top.
   function automatic logic [31:0] ptr_next(input logic [31:0] ptr,
                                            input logic [31:0] ll,
                                            input logic [31:0] ul);
      logic [31:0] inc;
      inc = ptr + 32'd4;
      return (inc == ul) ? ll : inc;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, one clock, first-word-fall-through head.
// Latency: pushed word is visible on dat_o the cycle after the push edge.
// Backpressure: push is taken when not full or when a pop happens in the same
// cycle; otherwise it is ignored. Ports: clk_i, rst_i, push_i/dat_i,
// pop_i/dat_o, full_o, empty_o.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dat_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == FULL_CNT);
   assign do_pop  = pop_i & ~empty_o;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push_i & (~full_o | do_pop);
   assign dat_o   = mem_q[rd_q];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage carries no reset; the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= dat_i;
   end

endmodule

// File: rtl/uart_rx_dma.sv
// UART receive DMA: packs received bytes little-endian into words, queues them
// and writes them to RAM, sharing the RAM port with a CPU Wishbone master.
// Ports: i_wb_clk/i_wb_rst; i_rx_done/i_rx_dat byte strobe; i_cpu_* CPU bus in,
// o_cpu_rdt/o_cpu_ack back; o_mem_* RAM bus out, i_mem_rdt/i_mem_ack back;
// o_wr_ptr next DMA address; o_ovf sticky word-drop flag.
module uart_rx_dma
   import uart_rx_dma_pkg::*;
#(
   parameter int          DEPTH  = 4,
   parameter logic [31:0] ADR_LL = DEF_ADR_LL,
   parameter logic [31:0] ADR_UL = DEF_ADR_UL
) (
   input  logic        i_wb_clk,
   input  logic        i_wb_rst,
   input  logic        i_rx_done,
   input  logic [7:0]  i_rx_dat,
   input  logic [31:0] i_cpu_adr,
   input  logic        i_cpu_cyc,
   input  logic        i_cpu_we,
   input  logic [3:0]  i_cpu_sel,
   input  logic [31:0] i_cpu_dat,
   output logic [31:0] o_cpu_rdt,
   output logic        o_cpu_ack,
   output logic [31:0] o_mem_adr,
   output logic        o_mem_cyc,
   output logic        o_mem_we,
   output logic [3:0]  o_mem_sel,
   output logic [31:0] o_mem_dat,
   input  logic [31:0] i_mem_rdt,
   input  logic        i_mem_ack,
   output logic [31:0] o_wr_ptr,
   output logic        o_ovf
);

   arb_state_e  state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] part_q;
   logic [31:0] wr_ptr_q, wr_ptr_d;
   logic        ovf_q, ovf_d;

   logic        push, pop;
   logic        fifo_full, fifo_empty;
   logic [31:0] fifo_head;

   // The 4th byte goes straight into the pushed word, not via part_q.
   assign push = i_rx_done & (cnt_q == 2'd3);
   assign pop  = (state_q == ARB_DMA) & i_mem_ack;

   sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
      .clk_i   (i_wb_clk),
      .rst_i   (i_wb_rst),
      .push_i  (push),
      .dat_i   ({i_rx_dat, part_q}),
      .pop_i   (pop),
      .dat_o   (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      cnt_d    = i_rx_done ? cnt_q + 2'd1 : cnt_q;
      wr_ptr_d = pop ? ptr_next(wr_ptr_q, ADR_LL, ADR_UL) : wr_ptr_q;
      ovf_d    = ovf_q | (push & fifo_full & ~pop);
   end

   always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
      if (i_wb_rst) begin
         state_q  <= ARB_IDLE;
         cnt_q    <= 2'd0;
         wr_ptr_q <= ADR_LL;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge i_wb_clk) begin
      if (i_rx_done) begin
         case (cnt_q)
            2'd0:    part_q[7:0]   <= i_rx_dat;
            2'd1:    part_q[15:8]  <= i_rx_dat;
            2'd2:    part_q[23:16] <= i_rx_dat;
            default: part_q        <= part_q;
         endcase
      end
   end

   // Arbiter: CPU wins from IDLE; every RAM access returns through IDLE so a
   // request arriving while the other master owns the bus waits one turn.
   always_comb begin
      state_d   = state_q;
      o_mem_cyc = 1'b0;
      o_mem_we  = 1'b0;
      o_mem_sel = 4'b0000;
      o_mem_adr = wr_ptr_q;
      o_mem_dat = fifo_head;
      o_cpu_ack = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (i_cpu_cyc)        state_d = ARB_CPU;
            else if (!fifo_empty) state_d = ARB_DMA;
         end
         ARB_CPU: begin
            // The CPU master holds cyc until acked, so ack is the only exit.
            o_mem_cyc = i_cpu_cyc;
            o_mem_we  = i_cpu_we;
            o_mem_sel = i_cpu_sel;
            o_mem_adr = i_cpu_adr;
            o_mem_dat = i_cpu_dat;
            o_cpu_ack = i_mem_ack;
            if (i_mem_ack) state_d = ARB_IDLE;
         end
         ARB_DMA: begin
            o_mem_cyc = 1'b1;
            o_mem_we  = 1'b1;
            o_mem_sel = 4'b1111;
            if (i_mem_ack) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   assign o_cpu_rdt = i_mem_rdt;
   assign o_wr_ptr  = wr_ptr_q;
   assign o_ovf     = ovf_q;

endmodule

// File: doc/uart_rx_dma.md
UART_RX_DMA -- requirements
Module: uart_rx_dma

Interface
REQ-001 Parameter DEPTH, default 4: word FIFO depth, power of two, at least 2.
REQ-002 Parameter ADR_LL, default 32'h00C00000: receive-window lower limit, inclusive and word aligned.
REQ-003 Parameter ADR_UL, default 32'h00C10000: receive-window upper limit, exclusive and word aligned.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
- i_wb_clk  in  1  sole clock; all state on the rising edge.
- i_wb_rst  in  1  reset, asynchronous, active-high.
- i_rx_done  in  1  one-cycle pulse: received byte valid.
- i_rx_dat  in  8  received byte, sampled when i_rx_done=1.
- i_cpu_adr  in  32  CPU Wishbone address.
- i_cpu_cyc  in  1  CPU cycle request.
- i_cpu_we  in  1  CPU write enable.
- i_cpu_sel  in  4  CPU byte selects.
- i_cpu_dat  in  32  CPU write data.
- o_cpu_rdt  out  32  CPU read data (equals i_mem_rdt).
- o_cpu_ack  out  1  CPU acknowledge.
- o_mem_adr  out  32  RAM address.
- o_mem_cyc  out  1  RAM cycle.
- o_mem_we  out  1  RAM write enable.
- o_mem_sel  out  4  RAM byte selects.
- o_mem_dat  out  32  RAM write data.
- i_mem_rdt  in  32  RAM read data.
- i_mem_ack  in  1  RAM acknowledge.
- o_wr_ptr  out  32  next DMA write address.
- o_ovf  out  1  sticky overflow flag.

Function
REQ-005 The packer SHALL assemble bytes little-endian: byte n of each group of 4 goes to bits [8n+7:8n], with a 2-bit counter that wraps 3 to 0.
REQ-006 On the 4th byte, the assembled word SHALL be pushed into the FIFO in the same edge that captures that byte.
REQ-007 A push SHALL be accepted if the FIFO is not full, or if a pop occurs in the same cycle.
REQ-008 If neither condition in REQ-007 holds, the word SHALL be dropped, o_ovf SHALL be set and held until reset, and the packer counter SHALL still wrap to 0.
REQ-009 The arbiter FSM SHALL have states IDLE, CPU and DMA, with IDLE as the reset state.
REQ-010 From IDLE, the FSM SHALL go to CPU if i_cpu_cyc=1; otherwise to DMA if the FIFO is non-empty; otherwise stay in IDLE. The CPU has priority.
REQ-011 In IDLE, o_mem_cyc, o_mem_we and o_cpu_ack SHALL be 0.
REQ-012 In CPU, the o_mem_* outputs SHALL equal the i_cpu_* inputs combinationally, and o_cpu_ack SHALL equal i_mem_ack.
REQ-013 In CPU, i_mem_ack SHALL return the FSM to IDLE.
REQ-014 In DMA, the block SHALL drive o_mem_cyc=1, o_mem_we=1, o_mem_sel=4'b1111, o_mem_adr=o_wr_ptr and o_mem_dat=FIFO head.
REQ-015 In DMA, o_cpu_ack SHALL be 0; a CPU request arriving during DMA SHALL wait and is served after DMA returns to IDLE.
REQ-016 In DMA, i_mem_ack SHALL pop the FIFO, advance o_wr_ptr by 4 and return the FSM to IDLE.
REQ-017 o_wr_ptr SHALL wrap to ADR_LL when o_wr_ptr+4 equals ADR_UL. Pointer arithmetic is 32-bit unsigned, and o_wr_ptr never leaves [ADR_LL, ADR_UL).
REQ-018 A CPU access costs exactly 1 extra cycle (IDLE to CPU) before it reaches the RAM. A DMA word reaches the RAM at least 2 cycles after its push.
REQ-019 A simultaneous push and pop at any fill level SHALL leave the FIFO count unchanged.
REQ-020 An i_rx_done pulse during any arbiter state SHALL be captured; byte capture never stalls.

Reset
REQ-021 Reset SHALL asynchronously force:
- FSM to IDLE;
- FIFO to empty;
- packer counter to 0;
- o_wr_ptr to ADR_LL;
- o_ovf, o_mem_cyc, o_mem_we and o_cpu_ack to 0.
REQ-022 Reset during DMA or CPU SHALL abandon the cycle: o_mem_cyc drops immediately and no pop occurs.
REQ-023 FIFO storage and partial-word data SHALL need no reset.

Structure
REQ-024 The arbiter state encoding and the default ADR_LL/ADR_UL constants SHALL live in the shared servant package.
REQ-025 The word FIFO SHALL be a separate sub-module, sync_fifo (parameters WIDTH, DEPTH), with push/pop/full/empty ports.
REQ-026 Packer, arbiter and pointer logic SHALL remain in uart_rx_dma.

Verification
REQ-027 Pulse bytes 11,22,33,44 with RAM idle -> one RAM write of 32'h44332211 at 32'h00C00000, sel=1111; o_wr_ptr becomes 32'h00C00004.
REQ-028 Hold i_cpu_cyc=1 (read, adr 0x100) while the 4th byte arrives -> CPU is served first and acked; the DMA write follows on the next IDLE.
REQ-029 Preload o_wr_ptr at 32'h00C0FFFC and send 8 bytes -> writes go to 32'h00C0FFFC, then 32'h00C00000.
REQ-030 Stall i_mem_ack=0 and send 4*(DEPTH+1) bytes -> FIFO full and o_ovf=1; after acks, exactly DEPTH words are written.
REQ-031 Assert i_wb_rst mid-DMA with 2 bytes partially packed -> o_mem_cyc=0 immediately, o_wr_ptr=ADR_LL, and the next 4 bytes form a fresh word.
REQ-032 Issue the CPU request in the cycle the DMA ack occurs -> FSM goes DMA to IDLE to CPU; no ack is lost and no duplicate ack occurs.
